// File: rtl/demx1to4_reg_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
package demx_pkg;

    localparam int unsigned DEMX_W = 4;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/demx1to4_reg_if.sv
// Producer / consumer bundle for demx1to4_reg: one input stream, four output channels.
interface demx_if #(
    parameter int unsigned W = demx_pkg::DEMX_W
) ();

    logic [W-1:0]   in_data;
    logic [1:0]     in_sel;
    logic           in_en;
    logic           in_valid;
    logic           in_ready;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [7:0]     drop_cnt;

    modport master (
        output in_data, in_sel, in_en, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop_cnt
    );

    modport slave (
        input  in_data, in_sel, in_en, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop_cnt
    );

endinterface

// File: rtl/demx1to4_reg_slot.sv
// One-entry output register with valid bit; a load on a draining edge keeps valid high.
module demx_slot #(
    parameter int unsigned W = demx_pkg::DEMX_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         drain_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         can_load_o
);

    logic [W-1:0] data_d, data_q;
    logic         valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = load_data_i;
            valid_d = 1'b1;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign can_load_o = !valid_q || drain_i;

endmodule

// File: rtl/demx1to4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel handshake and a saturating discard counter.
module demx1to4_reg
    import demx_pkg::*;
#(
    parameter int unsigned W = DEMX_W
) (
    input logic  clk,
    input logic  rst,
    demx_if.slave bus
);

    logic [3:0]        load;
    logic [3:0]        can_load;
    logic [3:0]        slot_valid;
    logic [3:0][W-1:0] slot_data;
    logic              accept;
    logic [7:0]        drop_d, drop_q;

    // Discards never stall; routed beats wait only on their own channel.
    assign bus.in_ready = bus.in_en ? can_load[bus.in_sel] : 1'b1;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        load = '0;
        if (accept && bus.in_en) begin
            load[bus.in_sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_slot
        demx_slot #(.W(W)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load_i     (load[k]),
            .load_data_i(bus.in_data[W-1:0]),
            .drain_i    (bus.out_ready[k]),
            .data_o     (slot_data[k]),
            .valid_o    (slot_valid[k]),
            .can_load_o (can_load[k])
        );
    end

    assign bus.out_data  = slot_data;
    assign bus.out_valid = slot_valid;

    always_comb begin
        drop_d = drop_q;
        if (accept && !bus.in_en && drop_q != DROP_MAX) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_demx1to4_reg.sv
// Directed, table-driven bench for demx1to4_reg.
module tb_demx1to4_reg;
    import demx_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    demx_if #(.W(4)) bus ();

    demx1to4_reg #(.W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  data;
        logic [1:0]  sel;
        logic        en;
        logic        valid;
        logic [3:0]  oready;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [15:0] exp_od;
        logic [7:0]  exp_drop;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] d, input logic [1:0] s, input logic e,
                         input logic v, input logic [3:0] orr);
        bus.in_data   = d;
        bus.in_sel    = s;
        bus.in_en     = e;
        bus.in_valid  = v;
        bus.out_ready = orr;
    endtask

    // Advance one edge and move to a sampling point 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(4'h0, CH_A, 1'b1, 1'b0, 4'hF);

        //          data  sel   en    vld   ordy  rdy   ov       od        drop
        vecs[0]  = '{4'h1, CH_A, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0001, 16'h0001, 8'd0};
        vecs[1]  = '{4'h2, CH_B, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0010, 16'h0021, 8'd0};
        vecs[2]  = '{4'h4, CH_C, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0100, 16'h0421, 8'd0};
        vecs[3]  = '{4'h8, CH_D, 1'b1, 1'b1, 4'hF, 1'b1, 4'b1000, 16'h8421, 8'd0};
        vecs[4]  = '{4'h0, CH_A, 1'b1, 1'b0, 4'hF, 1'b1, 4'b0000, 16'h8421, 8'd0};
        vecs[5]  = '{4'h3, CH_B, 1'b1, 1'b1, 4'hD, 1'b1, 4'b0010, 16'h8431, 8'd0};
        vecs[6]  = '{4'h5, CH_B, 1'b1, 1'b1, 4'hD, 1'b0, 4'b0010, 16'h8431, 8'd0};
        vecs[7]  = '{4'h5, CH_B, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0010, 16'h8451, 8'd0};
        vecs[8]  = '{4'hC, CH_C, 1'b1, 1'b1, 4'hD, 1'b1, 4'b0110, 16'h8C51, 8'd0};
        vecs[9]  = '{4'h0, CH_B, 1'b1, 1'b0, 4'hD, 1'b0, 4'b0010, 16'h8C51, 8'd0};
        vecs[10] = '{4'hF, CH_A, 1'b0, 1'b1, 4'hD, 1'b1, 4'b0010, 16'h8C51, 8'd1};
        vecs[11] = '{4'hF, CH_A, 1'b0, 1'b1, 4'hD, 1'b1, 4'b0010, 16'h8C51, 8'd2};
        vecs[12] = '{4'hF, CH_A, 1'b0, 1'b1, 4'hD, 1'b1, 4'b0010, 16'h8C51, 8'd3};
        vecs[13] = '{4'h0, CH_A, 1'b1, 1'b0, 4'hF, 1'b1, 4'b0000, 16'h8C51, 8'd3};

        tick();
        tick();
        rst = 1'b0;
        check("reset out_valid", 32'(bus.out_valid), 32'h0);
        check("reset out_data", 32'(bus.out_data), 32'h0);
        check("reset drop_cnt", 32'(bus.drop_cnt), 32'h0);
        check("reset in_ready", 32'(bus.in_ready), 32'h1);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].data, vecs[i].sel, vecs[i].en, vecs[i].valid, vecs[i].oready);
            #3;
            check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
            tick();
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].exp_od));
            check($sformatf("vec%0d drop_cnt", i), 32'(bus.drop_cnt), 32'(vecs[i].exp_drop));
        end

        // Saturation: 300 further discards from 3 must stop at 255.
        drive(4'h0, CH_A, 1'b0, 1'b1, 4'hF);
        for (int i = 0; i < 251; i++) tick();
        check("drop_cnt before sat", 32'(bus.drop_cnt), 32'd254);
        for (int i = 0; i < 49; i++) tick();
        check("drop_cnt saturated", 32'(bus.drop_cnt), 32'd255);
        check("discard in_ready", 32'(bus.in_ready), 32'h1);
        check("discard out_valid", 32'(bus.out_valid), 32'h0);

        // Fill a and d with consumers stalled, then reset with a beat offered.
        drive(4'h9, CH_A, 1'b1, 1'b1, 4'h0);
        tick();
        drive(4'h6, CH_D, 1'b1, 1'b1, 4'h0);
        tick();
        check("fill out_valid", 32'(bus.out_valid), 32'b1001);
        check("fill out_data", 32'(bus.out_data), 32'h6C59);
        drive(4'h7, CH_B, 1'b1, 1'b1, 4'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(4'h0, CH_A, 1'b1, 1'b0, 4'h0);
        check("midrst out_valid", 32'(bus.out_valid), 32'h0);
        check("midrst out_data", 32'(bus.out_data), 32'h0);
        check("midrst drop_cnt", 32'(bus.drop_cnt), 32'h0);
        tick();
        check("post-rst out_valid", 32'(bus.out_valid), 32'h0);
        check("post-rst in_ready", 32'(bus.in_ready), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demx1to4_reg.md
# demx1to4_reg

Registered 1-to-4 demultiplexer that steers a 4-bit input stream to one of four output channels selected by a 2-bit code, with a per-channel valid/ready handshake and a one-entry output register per channel. It is the distribution-side counterpart of the 4-to-1 mux: a producer feeds one stream in, and four consumers each drain their own channel independently. Beats offered while the block is disabled are accepted and discarded, and a saturating counter records them for debug.

## Interface

- W, default 4, data width of the input and of each output channel
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_data  input  W  input beat
- in_sel  input  2  destination channel: 0=a, 1=b, 2=c, 3=d
- in_en  input  1  1 = route beat; 0 = discard beat
- in_valid  input  1  producer offers in_data/in_sel/in_en
- in_ready  output  1  block accepts the beat this cycle
- out_data  output  4*W  channel k occupies bits [k*W +: W]
- out_valid  output  4  channel k holds an undelivered beat
- out_ready  input  4  consumer k takes its beat this cycle
- drop_cnt  output  8  number of beats discarded, saturating

## Operation

- Accept: in_valid && in_ready on a rising clk edge.
- in_ready is combinational:
  - in_en=1: in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - in_en=0: in_ready = 1.
- Accept with in_en=1: slot[in_sel] loads in_data and sets out_valid[in_sel]. Other slots are untouched.
- Accept with in_en=0: no slot changes. drop_cnt increments, saturating at 255 with no wrap.
- Drain: out_valid[k] && out_ready[k] clears out_valid[k] unless the same edge reloads slot k.
- Simultaneous drain and reload of the same slot: the new data loads and out_valid stays 1. Full throughput, one beat per cycle per channel.
- When out_valid[k] is 0, out_data[k] keeps its last loaded value. It is not zeroed. Consumers must qualify data with valid.
- A stalled channel (valid=1, ready=0) back-pressures only beats addressed to it. Beats to other channels and discards proceed.
- out_data[k] and out_valid[k] are stable while out_valid[k]=1 and out_ready[k]=0.
- in_sel and in_en are sampled only on accept. Their values are don't-care when in_valid=0.

## Timing

- Latency: a beat accepted at edge N is visible on out_data/out_valid after edge N. Latency is 1 cycle.
- Reset, synchronous, rst=1 at an edge:
  - out_valid=0, out_data=0, drop_cnt=0.
  - Reset dominates any accept or drain on that edge.
  - in_ready follows its equation from the reset state. With all slots empty, in_ready=1 during reset. Beats presented during reset are lost and not counted.
- Reset mid-operation discards all held beats with no drain indication.
- There is no combinational path from in_data to out_data.
- There is a combinational path from out_ready and in_sel to in_ready. This path is documented and allowed.

## Structure

- Package demx_pkg:
  - DEMX_W (=4) default width.
  - Channel constants CH_A=2'd0, CH_B=2'd1, CH_C=2'd2, CH_D=2'd3.
  - DROP_MAX=8'hFF.
- Sub-module demx_slot:
  - One output register with a valid bit.
  - Inputs: load, load_data, drain.
  - Outputs: data, valid, can_load = !valid || drain.
  - Instantiated 4× in a generate loop.
- The top level holds the sel decode, the in_ready mux, and the drop counter.

## Test plan

- Reset then route: in_en=1, sel=0..3 with in_data=0001/0010/0100/1000, one beat per cycle, all out_ready=1.
  - Each channel shows its value with out_valid pulsing for exactly one cycle, one cycle after accept.
  - drop_cnt stays 0.
- Back-pressure: out_ready[1]=0, send two beats to sel=1 (0011, then 0101).
  - First beat is accepted.
  - Second is held with in_ready=0 and out_data[b]=0011 stable.
  - Raise out_ready[1]: second beat accepted on the same edge the first drains, and out_valid[1] stays 1.
- Isolation: channel b stalled full, beat 1100 to sel=2 → accepted immediately, out_data[c]=1100, channel b unchanged.
- Discard: in_en=0 for 3 beats, sel=0 → in_ready=1, no out_valid change, drop_cnt=3. Drive 300 discards → drop_cnt=255.
- Reset mid-operation: fill channels a and d with out_ready=0, then assert rst for one cycle.
  - Next cycle: out_valid=0000, out_data=0, drop_cnt=0.
  - A beat during the reset cycle is not delivered.
